data_bus_arbiter: RTL and testbench

- Shares the single data-memory/IO bus between two requesters: the CPU datapath's load/store port and an external loader/debug (ext) port.
- Sequences each access with a programmable number of wait states.
- Returns read data and a one-cycle ready pulse to the granted requester.
- Drives cpu_stall so the control unit can hold the PC while the CPU is waiting.
- Sits between the datapath address decoder and DataMemory/IO.

---
 rtl/data_bus_arb_pkg.sv | 17 +
 rtl/arb_rr2.sv | 48 ++++
 rtl/data_bus_arbiter.sv | 115 +++++++++++
 tb/tb_data_bus_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_arb_pkg.sv
// Shared types for the two-requester data bus arbiter.
package data_bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef enum logic {
      GRANT_CPU = 1'b0,
      GRANT_EXT = 1'b1
   } grant_e;

   localparam int WAIT_MAX = 15;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester tie-break with last-grant memory; grants only while arb_en (IDLE).
// DATA_BUS_ARB_CPU_PRIORITY_EN selects fixed CPU priority instead of round-robin.
module arb_rr2
   import data_bus_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       arb_en,
   input  logic       cpu_req,
   input  logic       ext_req,
   output logic [1:0] grant,
   output logic       grant_valid
);

`ifdef DATA_BUS_ARB_CPU_PRIORITY_EN
   always_comb begin
      grant = 2'b00;
      if (arb_en) begin
         if (cpu_req)      grant[GRANT_CPU] = 1'b1;
         else if (ext_req) grant[GRANT_EXT] = 1'b1;
      end
      grant_valid = |grant;
   end
`else
   grant_e last_grant;

   // Starts at EXT so the first tie after reset goes to the CPU.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              last_grant <= GRANT_EXT;
      else if (grant_valid) last_grant <= grant[GRANT_EXT] ? GRANT_EXT : GRANT_CPU;
   end

   always_comb begin
      grant = 2'b00;
      if (arb_en) begin
         if (cpu_req && ext_req) begin
            if (last_grant == GRANT_EXT) grant[GRANT_CPU] = 1'b1;
            else                         grant[GRANT_EXT] = 1'b1;
         end else begin
            grant[GRANT_CPU] = cpu_req;
            grant[GRANT_EXT] = ext_req;
         end
      end
      grant_valid = |grant;
   end
`endif

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares one memory/IO bus between the CPU load/store port and an ext loader port,
// with WAIT_CYCLES wait states per access. Option: DATA_BUS_ARB_CPU_PRIORITY_EN.
module data_bus_arbiter
   import data_bus_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 1,
   parameter int CNT_W       = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              cpu_stall,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              ext_ready,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic              bus_we,
   output logic              bus_re,
   input  logic [DATA_W-1:0] bus_rdata
);

   localparam int              WAIT_EFF = (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_EFF);

   state_e             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   grant_e             winner;
   logic               lat_we;
   logic [1:0]         grant;
   logic               grant_valid;

   arb_rr2 u_arb (
      .clk         (clk),
      .rst         (rst),
      .arb_en      (state == IDLE),
      .cpu_req     (cpu_req),
      .ext_req     (ext_req),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_valid) state_nxt = ACCESS;
         ACCESS:  if (cnt == '0)   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Requester fields are captured at grant so later input changes cannot disturb the access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         lat_we    <= 1'b0;
         winner    <= GRANT_CPU;
         cpu_rdata <= '0;
         ext_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  cnt <= CNT_INIT;
                  if (grant[GRANT_EXT]) begin
                     winner    <= GRANT_EXT;
                     lat_we    <= ext_we;
                     bus_addr  <= ext_addr;
                     bus_wdata <= ext_wdata;
                  end else begin
                     winner    <= GRANT_CPU;
                     lat_we    <= cpu_we;
                     bus_addr  <= cpu_addr;
                     bus_wdata <= cpu_wdata;
                  end
               end
            end
            ACCESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (!lat_we) begin
                  if (winner == GRANT_CPU) cpu_rdata <= bus_rdata;
                  else                     ext_rdata <= bus_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus_we    = (state == ACCESS) &&  lat_we;
   assign bus_re    = (state == ACCESS) && !lat_we;
   assign cpu_ready = (state == DONE) && (winner == GRANT_CPU);
   assign ext_ready = (state == DONE) && (winner == GRANT_EXT);
   assign cpu_stall = cpu_req & ~cpu_ready;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: transaction-timeline model checked every cycle plus directed literals.
module tb_data_bus_arbiter;

   localparam int W = 1;
`ifdef DATA_BUS_ARB_CPU_PRIORITY_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 0, cpu_we = 0, ext_req = 0, ext_we = 0;
   logic [31:0] cpu_addr = 0, cpu_wdata = 0, ext_addr = 0, ext_wdata = 0;
   logic [31:0] cpu_rdata, ext_rdata, bus_addr, bus_wdata, bus_rdata;
   logic        cpu_ready, cpu_stall, ext_ready, bus_we, bus_re;

   // Second instance with zero wait states
   logic        z_cpu_req = 0, z_cpu_we = 0, z_ext_req = 0, z_ext_we = 0;
   logic [31:0] z_cpu_addr = 0, z_cpu_wdata = 0, z_ext_addr = 0, z_ext_wdata = 0, z_bus_rdata = 0;
   logic [31:0] z_cpu_rdata, z_ext_rdata, z_bus_addr, z_bus_wdata;
   logic        z_cpu_ready, z_cpu_stall, z_ext_ready, z_bus_we, z_bus_re;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   bit order[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // Memory: 0x10 holds a known word, everything else is derived from the address.
   assign bus_rdata = (bus_addr == 32'h10) ? 32'hDEADBEEF : {bus_addr[15:0], ~bus_addr[15:0]};

   data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W), .CNT_W(4)) u_dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_stall(cpu_stall),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_rdata(ext_rdata), .ext_ready(ext_ready),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
      .bus_rdata(bus_rdata)
   );

   data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0), .CNT_W(4)) u_dut0 (
      .clk(clk), .rst(rst),
      .cpu_req(z_cpu_req), .cpu_we(z_cpu_we), .cpu_addr(z_cpu_addr), .cpu_wdata(z_cpu_wdata),
      .cpu_rdata(z_cpu_rdata), .cpu_ready(z_cpu_ready), .cpu_stall(z_cpu_stall),
      .ext_req(z_ext_req), .ext_we(z_ext_we), .ext_addr(z_ext_addr), .ext_wdata(z_ext_wdata),
      .ext_rdata(z_ext_rdata), .ext_ready(z_ext_ready),
      .bus_addr(z_bus_addr), .bus_wdata(z_bus_wdata), .bus_we(z_bus_we), .bus_re(z_bus_re),
      .bus_rdata(z_bus_rdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: each granted transaction occupies cycles s..s+W+2; strobes at s+1..s+W+1, ready at s+W+2.
   int          s = -100;
   bit          t_ext = 0, last_ext = 1;
   logic        t_we = 0;
   logic [31:0] t_addr = 0, t_wdata = 0;
   logic [31:0] m_addr = 0, m_wdata = 0, m_crd = 0, m_erd = 0;

   always @(negedge clk) begin
      int   ph;
      bit   busy;
      logic e_re, e_we, e_cr, e_er;
      if (rst) begin
         s = -100; last_ext = 1; m_addr = 0; m_wdata = 0; m_crd = 0; m_erd = 0;
         chk("rst_bus_addr", bus_addr, 0);
         chk("rst_bus_wdata", bus_wdata, 0);
         chk("rst_strobes", {30'd0, bus_we, bus_re}, 0);
         chk("rst_ready", {30'd0, cpu_ready, ext_ready}, 0);
         chk("rst_cpu_rdata", cpu_rdata, 0);
         chk("rst_ext_rdata", ext_rdata, 0);
         chk("rst_stall", {31'd0, cpu_stall}, {31'd0, cpu_req});
      end else begin
         busy = (cyc - s) < W + 3;
         if (!busy && (cpu_req || ext_req)) begin
            if (cpu_req && ext_req) t_ext = PRIO ? 1'b0 : !last_ext;
            else                    t_ext = ext_req;
            last_ext = t_ext;
            s = cyc;
            busy = 1;
            t_we    = t_ext ? ext_we    : cpu_we;
            t_addr  = t_ext ? ext_addr  : cpu_addr;
            t_wdata = t_ext ? ext_wdata : cpu_wdata;
         end
         ph   = cyc - s;
         e_re = busy && ph >= 1 && ph <= W + 1 && !t_we;
         e_we = busy && ph >= 1 && ph <= W + 1 &&  t_we;
         e_cr = busy && ph == W + 2 && !t_ext;
         e_er = busy && ph == W + 2 &&  t_ext;
         chk("bus_re", {31'd0, bus_re}, {31'd0, e_re});
         chk("bus_we", {31'd0, bus_we}, {31'd0, e_we});
         chk("bus_addr", bus_addr, m_addr);
         chk("bus_wdata", bus_wdata, m_wdata);
         chk("cpu_ready", {31'd0, cpu_ready}, {31'd0, e_cr});
         chk("ext_ready", {31'd0, ext_ready}, {31'd0, e_er});
         chk("cpu_rdata", cpu_rdata, m_crd);
         chk("ext_rdata", ext_rdata, m_erd);
         chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, cpu_req & ~e_cr});
         if (busy && ph == 0) begin
            m_addr  = t_addr;
            m_wdata = t_wdata;
         end
         if (busy && ph == W + 1 && !t_we) begin
            if (t_ext) m_erd = bus_rdata;
            else       m_crd = bus_rdata;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (cpu_ready) order.push_back(1'b0);
         if (ext_ready) order.push_back(1'b1);
      end
   end

   // Called just after a rising edge; returns the cycle in which ready was seen.
   task automatic wait_ready(input bit ext, output int rc);
      int t;
      t  = 0;
      rc = -1;
      while (t < 40) begin
         @(negedge clk);
         if ((ext ? ext_ready : cpu_ready) === 1'b1) begin
            rc = cyc;
            break;
         end
         t++;
      end
      if (rc < 0) begin
         vectors++;
         miscompares++;
         $display("FAIL ready_timeout: %s got no ready within 40 cycles, required a pulse", ext ? "ext" : "cpu");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic op(input bit ext, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input bit keep, output int rc);
      if (ext) begin
         ext_req = 1; ext_we = we; ext_addr = addr; ext_wdata = wdata;
      end else begin
         cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      end
      wait_ready(ext, rc);
      if (!keep) begin
         if (ext) ext_req = 0;
         else     cpu_req = 0;
      end
   endtask

   initial begin
      int n0, r1, r2, ra, rb, rc2, rd;
      bit exp_order[4];

      @(negedge clk);
      chk("lit_rst_cpu_rdata", cpu_rdata, 32'h0);
      chk("lit_rst_bus_re", {31'd0, bus_re}, 32'h0);
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;

      // Single CPU read
      n0 = cyc;
      op(0, 0, 32'h10, 32'h0, 0, r1);
      chk("lit_cpu_rd_latency", r1 - n0, 3);
      chk("lit_cpu_rd_data", cpu_rdata, 32'hDEADBEEF);

      // CPU write leaves cpu_rdata alone
      op(0, 1, 32'h40, 32'hCAFE0001, 0, r1);
      chk("lit_cpu_wr_keeps_rdata", cpu_rdata, 32'hDEADBEEF);

      // Ext read
      op(1, 0, 32'h30, 32'h0, 0, r1);
      chk("lit_ext_rd_data", ext_rdata, 32'h0030FFCF);

      // Simultaneous requests, both held back-to-back for two accesses each
      order.delete();
      fork
         begin
            op(0, 0, 32'h50, 32'h0, 1, ra);
            op(0, 1, 32'h54, 32'h11111111, 0, rb);
         end
         begin
            op(1, 1, 32'h60, 32'h22222222, 1, rc2);
            op(1, 0, 32'h64, 32'h0, 0, rd);
         end
      join
      if (PRIO) exp_order = '{1'b0, 1'b0, 1'b1, 1'b1};
      else      exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
      chk("lit_order_len", order.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < order.size()) chk("lit_grant_order", {31'd0, order[i]}, {31'd0, exp_order[i]});
      end

      // Address change during ACCESS is ignored
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
      @(posedge clk); #1;
      cpu_addr = 32'h44;
      wait_ready(0, r1);
      chk("lit_addr_held", bus_addr, 32'h10);
      chk("lit_addr_held_data", cpu_rdata, 32'hDEADBEEF);
      cpu_req = 0;
      @(posedge clk); #1;

      // Reset in the middle of ACCESS
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
      @(posedge clk); #2;
      chk("lit_pre_rst_re", {31'd0, bus_re}, 32'h1);
      rst = 1;
      #1;
      chk("lit_rst_drops_re", {31'd0, bus_re}, 32'h0);
      chk("lit_rst_no_ready", {31'd0, cpu_ready}, 32'h0);
      @(posedge clk); #1;
      rst = 0;
      n0 = cyc;
      op(0, 0, 32'h10, 32'h0, 0, r1);
      chk("lit_post_rst_latency", r1 - n0, 3);

      // Back-to-back CPU accesses
      op(0, 0, 32'h70, 32'h0, 1, r1);
      op(0, 0, 32'h74, 32'h0, 0, r2);
      chk("lit_b2b_spacing", r2 - r1, 4);
      chk("lit_b2b_data", cpu_rdata, 32'h0074FF8B);

      // Zero-wait-state ext write on the second instance
      z_ext_req = 1; z_ext_we = 1; z_ext_addr = 32'h20; z_ext_wdata = 32'h12345678;
      @(negedge clk);
      chk("z_n_bus_we", {31'd0, z_bus_we}, 32'h0);
      @(negedge clk);
      chk("z_n1_bus_we", {31'd0, z_bus_we}, 32'h1);
      chk("z_n1_bus_addr", z_bus_addr, 32'h20);
      chk("z_n1_bus_wdata", z_bus_wdata, 32'h12345678);
      chk("z_n1_ext_ready", {31'd0, z_ext_ready}, 32'h0);
      @(negedge clk);
      chk("z_n2_ext_ready", {31'd0, z_ext_ready}, 32'h1);
      chk("z_n2_bus_we", {31'd0, z_bus_we}, 32'h0);
      chk("z_n2_cpu_ready", {31'd0, z_cpu_ready}, 32'h0);
      @(posedge clk); #1;
      z_ext_req = 0;
      @(negedge clk);
      chk("z_n3_ext_ready", {31'd0, z_ext_ready}, 32'h0);
      chk("z_n3_bus_re", {31'd0, z_bus_re}, 32'h0);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
